// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses anodes of leading zero digits).
module seg7_scan_ctrl #(
    parameter int N_DIG       = 4,
    parameter int REFRESH_CYC = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                     reloj,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [4*N_DIG-1:0]       digits_in,
    input  logic [N_DIG-1:0]         dp_in,
    output logic [3:0]               dec_bin_out,
    input  logic [6:0]               dec_seg_in,
    output logic [6:0]               seg_out,
    output logic                     dp_out,
    output logic [N_DIG-1:0]         an_out,
    output logic [$clog2(N_DIG)-1:0] digit_idx,
    output logic                     frame_tick
);

    localparam int IDX_W = $clog2(N_DIG);
    localparam int CNT_W = $clog2(REFRESH_CYC);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYC - BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [4*N_DIG-1:0]   shadow_code, shadow_code_nx;
    logic [N_DIG-1:0]     shadow_dp, shadow_dp_nx;
    logic [IDX_W-1:0]     idx_nx, idx_inc;
    logic [3:0]           dec_bin_nx;
    logic [6:0]           seg_nx;
    logic                 dp_nx;
    logic [N_DIG-1:0]     an_nx;
    logic                 tick_nx;
    logic                 show_en;
    logic [N_DIG-1:0]     show_mask;

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit k (k > 0) and every digit above it hold code 0.
    function automatic logic lead_zero(input logic [4*N_DIG-1:0] codes,
                                       input logic [IDX_W-1:0]   k);
        logic z;
        z = (k != '0);
        for (int i = 0; i < N_DIG; i++) begin
            if (i >= int'(k) && codes[4*i +: 4] != 4'd0)
                z = 1'b0;
        end
        return z;
    endfunction

    assign show_en = ~lead_zero(shadow_code, digit_idx);
`else
    assign show_en = 1'b1;
`endif

    assign idx_inc = digit_idx + 1'b1;

    // Anode pattern for the digit being shown: one bit low, or none when suppressed.
    always_comb begin
        show_mask = '1;
        for (int i = 0; i < N_DIG; i++) begin
            if (show_en && int'(digit_idx) == i)
                show_mask[i] = 1'b0;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        idx_nx         = digit_idx;
        shadow_code_nx = shadow_code;
        shadow_dp_nx   = shadow_dp;
        dec_bin_nx     = dec_bin_out;
        seg_nx         = 7'h7F;
        dp_nx          = 1'b1;
        an_nx          = '1;
        tick_nx        = 1'b0;

        if (!en) begin
            // Dropping enable wins over everything, including a frame wrap.
            state_nx   = IDLE;
            cnt_nx     = '0;
            idx_nx     = '0;
            dec_bin_nx = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx       = BLANK;
                    cnt_nx         = '0;
                    idx_nx         = '0;
                    shadow_code_nx = digits_in;
                    shadow_dp_nx   = dp_in;
                    dec_bin_nx     = digits_in[3:0];
                    tick_nx        = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                        seg_nx   = dec_seg_in;
                        dp_nx    = ~shadow_dp[digit_idx];
                        an_nx    = show_mask;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        if (digit_idx == IDX_LAST) begin
                            // Frame boundary: the only point where new input values are taken.
                            idx_nx         = '0;
                            shadow_code_nx = digits_in;
                            shadow_dp_nx   = dp_in;
                            dec_bin_nx     = digits_in[3:0];
                            tick_nx        = 1'b1;
                        end else begin
                            idx_nx     = idx_inc;
                            dec_bin_nx = shadow_code[{idx_inc, 2'b00} +: 4];
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                        seg_nx = dec_seg_in;
                        dp_nx  = ~shadow_dp[digit_idx];
                        an_nx  = show_mask;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            shadow_code <= '0;
            shadow_dp   <= '0;
            dec_bin_out <= 4'd0;
            seg_out     <= 7'h7F;
            dp_out      <= 1'b1;
            an_out      <= '1;
            frame_tick  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            digit_idx   <= idx_nx;
            shadow_code <= shadow_code_nx;
            shadow_dp   <= shadow_dp_nx;
            dec_bin_out <= dec_bin_nx;
            seg_out     <= seg_nx;
            dp_out      <= dp_nx;
            an_out      <= an_nx;
            frame_tick  <= tick_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-cycle comparison against a slot/phase arithmetic model.
module tb_seg7_scan_ctrl;

    localparam int N_DIG       = 4;
    localparam int REFRESH_CYC = 20;
    localparam int BLANK_CYC   = 4;
    localparam int FRAME       = N_DIG * REFRESH_CYC;

    logic        reloj = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  dec_bin_out;
    logic [6:0]  dec_seg_in = 7'h7F;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [15:0] m_code = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;

    seg7_scan_ctrl #(
        .N_DIG(N_DIG),
        .REFRESH_CYC(REFRESH_CYC),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .reloj(reloj),
        .rst_n(rst_n),
        .en(en),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .dec_bin_out(dec_bin_out),
        .dec_seg_in(dec_seg_in),
        .seg_out(seg_out),
        .dp_out(dp_out),
        .an_out(an_out),
        .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    initial forever #5 reloj = ~reloj;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // External decoder with one cycle of latency.
    always @(posedge reloj) dec_seg_in <= hex_seg(dec_bin_out);

    function automatic bit lz_hidden(input logic [15:0] code, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 0) return 1'b0;
        for (int k = slot; k < N_DIG; k++)
            if (code[4*k +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0d active=%0d)", tag, obs, exp, m_t, m_active);
        end
    endtask

    task automatic check_all();
        int         slot, ph;
        logic [3:0] e_an, e_bin;
        logic [6:0] e_seg;
        logic       e_dp, e_tick;
        logic [1:0] e_idx;
        if (!m_active) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_bin = 4'h0; e_idx = 2'd0; e_tick = 1'b0;
        end else begin
            slot   = m_t / REFRESH_CYC;
            ph     = m_t % REFRESH_CYC;
            e_bin  = m_code[4*slot +: 4];
            e_idx  = 2'(slot);
            e_tick = (m_t == 0);
            if (ph < BLANK_CYC) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_seg = hex_seg(e_bin);
                e_dp  = ~m_dp[slot];
                e_an  = lz_hidden(m_code, slot) ? 4'hF : ~(4'b0001 << slot);
            end
        end
        chk("an_out", 16'(an_out), 16'(e_an));
        chk("seg_out", 16'(seg_out), 16'(e_seg));
        chk("dp_out", 16'(dp_out), 16'(e_dp));
        chk("dec_bin_out", 16'(dec_bin_out), 16'(e_bin));
        chk("digit_idx", 16'(digit_idx), 16'(e_idx));
        chk("frame_tick", 16'(frame_tick), 16'(e_tick));
        chk("one_anode", 16'($countones(~an_out) <= 1), 16'd1);
    endtask

    task automatic model_edge();
        if (!rst_n || !en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1; m_t = 0; m_code = digits_in; m_dp = dp_in;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0; m_code = digits_in; m_dp = dp_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        model_edge();
        @(negedge reloj);
        check_all();
    endtask

    task automatic run_to(input int target);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!(m_active && m_t == target) && i < 4 * FRAME);
        chk("run_to_reached", 16'(m_active && m_t == target), 16'd1);
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame with 1234.
        digits_in = 16'h1234; dp_in = 4'b0000; en = 1'b1;
        repeat (FRAME) tick();

        // Mid-frame input change while digit 2 is shown; new values wait for the frame boundary.
        run_to(45);
        digits_in = 16'h5678; dp_in = 4'b0100;
        repeat (2 * FRAME) tick();

        // Randomized codes and decimal points changing at arbitrary times.
        repeat (5) begin
            digits_in = 16'($urandom);
            dp_in = 4'($urandom);
            repeat ($urandom_range(30, 140)) tick();
        end

        // Drop enable during SHOW of digit 1, then restart.
        run_to(30);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (FRAME) tick();

        // Enable drop coinciding with a frame wrap: IDLE, no tick.
        run_to(FRAME - 1);
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (30) tick();

        // Asynchronous reset between edges, mid-SHOW.
        run_to(50);
        #2 rst_n = 1'b0;
        #1 m_active = 1'b0;
        check_all();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (FRAME) tick();

        // Leading-zero patterns.
        digits_in = 16'h0050; dp_in = 4'b0000;
        run_to(0);
        repeat (FRAME) tick();
        digits_in = 16'h0000;
        run_to(0);
        repeat (FRAME) tick();

        // Random enable toggling and input churn.
        repeat (400) begin
            if ($urandom_range(0, 40) == 0) en = ~en;
            if ($urandom_range(0, 25) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 25) == 0) dp_in = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one external binary-to-7-segment decoder between all digits.
- Presents each digit's 4-bit code to the decoder, drives that digit's anode for a fixed slot, and inserts a blanking gap between digits to suppress ghosting.
- Sits between the Gray/binary datapath and the board display pins.

Parameters:
- N_DIG, 4, number of digits (2..8).
- REFRESH_CYC, 50000, cycles per digit slot including blanking (1 ms at 50 MHz).
- BLANK_CYC, 500, blanking cycles at the start of each slot; must satisfy 2 <= BLANK_CYC < REFRESH_CYC.

Ports:
- reloj, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, scan enable.
- digits_in, in, 4*N_DIG, digit codes; digit k = bits [4k+3:4k], digit 0 is least significant.
- dp_in, in, N_DIG, decimal point per digit, active-high.
- dec_bin_out, out, 4, code driven to the shared decoder.
- dec_seg_in, in, 7, active-low segment pattern returned by the decoder.
- seg_out, out, 7, active-low segments to the pins.
- dp_out, out, 1, active-low decimal point.
- an_out, out, N_DIG, active-low anodes.
- digit_idx, out, $clog2(N_DIG), digit currently being scanned.
- frame_tick, out, 1, one-cycle pulse at the start of each frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; an_out all 1; seg_out=7'h7F; dp_out=1; dec_bin_out=0; digit_idx=0; frame_tick=0; cnt=0; shadow register=0.
- States:
  - IDLE: anodes off. If en=1: latch digits_in and dp_in into the shadow register, digit_idx=0, frame_tick=1 for one cycle, cnt=0, go to BLANK.
  - BLANK: an_out all 1; seg_out=7'h7F; dp_out=1; dec_bin_out=shadow[digit_idx].
    - cnt counts 0..BLANK_CYC-1.
    - At cnt=BLANK_CYC-1: go to SHOW, cnt=0, and register seg_out<=dec_seg_in, dp_out<=~dp_shadow[digit_idx], an_out[digit_idx]<=0.
    - The gap is long enough to absorb a decoder latency of up to BLANK_CYC-1 cycles.
  - SHOW: only an_out[digit_idx] is low; seg_out<=dec_seg_in every cycle; dec_bin_out is held.
    - cnt counts 0..REFRESH_CYC-BLANK_CYC-1.
    - At the terminal count: go to BLANK, cnt=0, digit_idx<=digit_idx+1.
- Frame wrap:
  - When digit_idx=N_DIG-1 ends SHOW: digit_idx wraps to 0, the shadow reloads from the inputs, and frame_tick pulses for one cycle.
  - The shadow changes only at a frame boundary, so a frame never mixes old and new values.
- Enable drop: en=0 in any state forces IDLE on the next edge. Outputs then take their reset values except the shadow, which is held.
- Simultaneous events: frame wrap coinciding with en=0 resolves to IDLE; no frame_tick is issued.
- Frame period: N_DIG*REFRESH_CYC cycles exactly.
- Invariants:
  - At most one an_out bit is low at any time.
  - No an_out bit is low during BLANK.
- Mid-operation rst_n assertion: all outputs go to reset values immediately (asynchronously); scanning restarts from digit 0 after release if en=1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When a digit k>0 has shadow code 0 and every higher digit also has code 0, its anode stays high during its SHOW slot.
  - seg_out and dp_out follow the normal rules; slot timing is unchanged.
  - Digit 0 is always displayed.
- Undefined: every digit is displayed.

Test Plan (bench with N_DIG=4, REFRESH_CYC=20, BLANK_CYC=4, decoder modelled with 1-cycle latency):
- Reset then en=1, digits_in=16'h1234 -> frame_tick pulses once; dec_bin_out sequence 4,3,2,1 with a 20-cycle period; an_out=4'b1110, 1101, 1011, 0111, each low for 16 cycles after a 4-cycle all-high gap; seg_out equals the decoder pattern for each code.
- Change digits_in from 16'h1234 to 16'h5678 mid-frame while digit 2 is shown -> remaining digits still show 2,1; the next frame shows 8,7,6,5; frame_tick pulses every 80 cycles.
- dp_in=4'b0100 -> dp_out=0 only during digit 2's SHOW slot; dp_out=1 in all BLANK cycles.
- Drop en during SHOW of digit 1 -> next edge an_out=4'hF, seg_out=7'h7F; re-assert en -> restarts at digit 0 with frame_tick.
- Assert rst_n=0 asynchronously between clock edges mid-SHOW -> outputs go to reset values without waiting for a clock edge; every-cycle check confirms at most one anode is ever low.
- With LEADING_ZERO_BLANK_EN defined and digits_in=16'h0050 -> digits 3 and 2 keep an_out high in their slots; digits 1 and 0 are shown (0 is displayed). With digits_in=16'h0000, only digit 0 is shown.
